brick_field: RTL and testbench

Playfield owner for the brick game, directly upstream of the ball stage. Holds the brick map and paddle and composes the 192-bit occupancy word (index = row*16 + col, 12 rows × 16 cols) that the ball stage uses for collision. Advances the ball stage with a step strobe and clears the bricks the ball strikes. Also tracks score and lives, detects paddle misses, and reseeds the ball through its active-low reset.

---
 rtl/brick_field_pkg.sv | 36 +++
 rtl/brick_hit_resolver.sv | 57 +++++
 rtl/brick_field.sv | 168 ++++++++++++++++
 tb/tb_brick_field.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_field_pkg.sv
// Shared grid geometry, ball direction and game state encodings for the brick playfield.
package brick_field_pkg;

    localparam int ROWS          = 12;
    localparam int COLS          = 16;
    localparam int CELLS         = ROWS * COLS;
    localparam int PADDLE_ROW    = ROWS - 1;
    localparam int BALL_SEED_ROW = 9;
    localparam int BALL_SEED_COL = 7;

    // RIGHT travels toward lower column numbers, LEFT toward higher ones.
    typedef enum logic [1:0] {
        UP_RIGHT   = 2'b00,
        UP_LEFT    = 2'b01,
        DOWN_RIGHT = 2'b10,
        DOWN_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        SERVE = 3'd2,
        OVER  = 3'd3,
        WIN   = 3'd4
    } state_t;

    // A cell can hold a brick only inside the grid and above the paddle row.
    function automatic logic brick_cell(input int row, input int col);
        return (row >= 0) && (row < PADDLE_ROW) && (col >= 0) && (col < COLS);
    endfunction

    function automatic logic [7:0] cell_index(input int row, input int col);
        return 8'(row * COLS + col);
    endfunction

endpackage

// File: rtl/brick_hit_resolver.sv
// Combinational collision lookup: which bricks the ball strikes on its next step.
module brick_hit_resolver
    import brick_field_pkg::*;
(
    input  logic [CELLS-1:0] map,
    input  logic [3:0]       ball_row,
    input  logic [3:0]       ball_col,
    input  logic [1:0]       ball_dir,
    output logic [CELLS-1:0] clear_mask,
    output logic [1:0]       hit_count
);

    int         row_step;
    int         col_step;
    int         v_row;
    int         h_col;
    logic       v_ok;
    logic       h_ok;
    logic       d_ok;
    logic       v_hit;
    logic       h_hit;
    logic       d_hit;
    logic [7:0] v_idx;
    logic [7:0] h_idx;
    logic [7:0] d_idx;

    always_comb begin
        // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
        clear_mask = '0;
        hit_count  = '0;

        row_step = (dir_t'(ball_dir) == DOWN_RIGHT || dir_t'(ball_dir) == DOWN_LEFT) ? 1 : -1;
        col_step = (dir_t'(ball_dir) == UP_LEFT    || dir_t'(ball_dir) == DOWN_LEFT) ? 1 : -1;
        v_row    = int'(ball_row) + row_step;
        h_col    = int'(ball_col) + col_step;

        v_ok = brick_cell(v_row, int'(ball_col));
        h_ok = brick_cell(int'(ball_row), h_col);
        d_ok = brick_cell(v_row, h_col);

        v_idx = v_ok ? cell_index(v_row, int'(ball_col)) : 8'd0;
        h_idx = h_ok ? cell_index(int'(ball_row), h_col) : 8'd0;
        d_idx = d_ok ? cell_index(v_row, h_col)          : 8'd0;

        v_hit = v_ok & map[v_idx];
        h_hit = h_ok & map[h_idx];
        // The diagonal only counts when the ball grazes a corner with both edges open.
        d_hit = d_ok & map[d_idx] & ~v_hit & ~h_hit;

        if (v_hit) clear_mask[v_idx] = 1'b1;
        if (h_hit) clear_mask[h_idx] = 1'b1;
        if (d_hit) clear_mask[d_idx] = 1'b1;

        hit_count = {1'b0, v_hit} + {1'b0, h_hit} + {1'b0, d_hit};
    end

endmodule

// File: rtl/brick_field.sv
// Brick game playfield: brick map, paddle, score, lives and ball stage control.
// Define AUTOPILOT_EN to have the paddle track ball_col instead of the buttons.
module brick_field
    import brick_field_pkg::*;
#(
    parameter int PADDLE_W   = 4,
    parameter int BRICK_ROWS = 4,
    parameter int LIVES      = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic [3:0]       ball_row,
    input  logic [3:0]       ball_col,
    input  logic [1:0]       ball_dir,
    output logic [CELLS-1:0] data,
    output logic             ball_step,
    output logic             ball_rst_n,
    output logic [7:0]       score,
    output logic [1:0]       lives,
    output logic [2:0]       state
);

    localparam logic [3:0]       PADDLE_HOME = 4'((COLS - PADDLE_W) / 2);
    localparam logic [3:0]       PADDLE_MAX  = 4'(COLS - PADDLE_W);
    localparam logic [1:0]       LIVES_FULL  = 2'(LIVES);
    localparam logic [CELLS-1:0] MAP_FULL    = {{(CELLS - BRICK_ROWS * COLS){1'b0}},
                                                {(BRICK_ROWS * COLS){1'b1}}};

    state_t           state_q;
    state_t           state_d;
    logic [CELLS-1:0] map_q;
    logic [CELLS-1:0] map_d;
    logic [CELLS-1:0] map_cleared;
    logic [3:0]       paddle_q;
    logic [3:0]       paddle_d;
    logic [3:0]       paddle_moved;
    logic [7:0]       score_q;
    logic [7:0]       score_d;
    logic [7:0]       score_sat;
    logic [8:0]       score_sum;
    logic [1:0]       lives_q;
    logic [1:0]       lives_d;
    logic [CELLS-1:0] clear_mask;
    logic [1:0]       hit_count;
    logic [COLS-1:0]  paddle_cells;
    logic             miss;

    brick_hit_resolver u_hit_resolver (
        .map        (map_q),
        .ball_row   (ball_row),
        .ball_col   (ball_col),
        .ball_dir   (ball_dir),
        .clear_mask (clear_mask),
        .hit_count  (hit_count)
    );

    assign miss      = (ball_row == 4'(PADDLE_ROW));
    assign score_sum = {1'b0, score_q} + {7'd0, hit_count};
    assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];

`ifdef AUTOPILOT_EN
    int   target;
    logic unused_buttons;

    assign unused_buttons = btn_left ^ btn_right;

    always_comb begin
        target = int'(ball_col) - PADDLE_W / 2;
        if (target < 0) begin
            target = 0;
        end else if (target > int'(PADDLE_MAX)) begin
            target = int'(PADDLE_MAX);
        end
        paddle_moved = paddle_q;
        if (int'(paddle_q) < target) begin
            paddle_moved = paddle_q + 4'd1;
        end else if (int'(paddle_q) > target) begin
            paddle_moved = paddle_q - 4'd1;
        end
    end
`else
    always_comb begin
        paddle_moved = paddle_q;
        if (btn_left && !btn_right && paddle_q < PADDLE_MAX) begin
            paddle_moved = paddle_q + 4'd1;
        end else if (btn_right && !btn_left && paddle_q != 4'd0) begin
            paddle_moved = paddle_q - 4'd1;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        map_d       = map_q;
        paddle_d    = paddle_q;
        score_d     = score_q;
        lives_d     = lives_q;
        map_cleared = map_q & ~clear_mask;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = PLAY;
            end
            PLAY: begin
                if (tick && miss) begin
                    lives_d  = lives_q - 2'd1;
                    paddle_d = PADDLE_HOME;
                    state_d  = (lives_q == 2'd1) ? OVER : SERVE;
                end else if (tick) begin
                    map_d    = map_cleared;
                    score_d  = score_sat;
                    paddle_d = paddle_moved;
                    if (map_cleared == '0) state_d = WIN;
                end
            end
            SERVE: begin
                state_d = PLAY;
            end
            OVER, WIN: begin
                if (start) begin
                    state_d  = IDLE;
                    map_d    = MAP_FULL;
                    paddle_d = PADDLE_HOME;
                    score_d  = '0;
                    lives_d  = LIVES_FULL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            // NOTE: the map is a small flop field that must reload to a known pattern, so it is reset like any other register.
            map_q    <= MAP_FULL;
            paddle_q <= PADDLE_HOME;
            score_q  <= '0;
            lives_q  <= LIVES_FULL;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q  <= state_d;
            map_q    <= map_d;
            paddle_q <= paddle_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_paddle
        assign paddle_cells[c] = ({1'b0, paddle_q} <= 5'(c)) &&
                                 (5'(c) < {1'b0, paddle_q} + 5'(PADDLE_W));
    end

    assign data       = map_q | {paddle_cells, {(CELLS - COLS){1'b0}}};
    assign ball_rst_n = !(state_q == IDLE || state_q == SERVE);
    assign ball_step  = tick && (state_q == PLAY) && !miss;
    assign score      = score_q;
    assign lives      = lives_q;
    assign state      = state_q;

endmodule

// File: tb/tb_brick_field.sv
// Self-checking bench for brick_field: hit vector table plus scoreboarded game sequences.
module tb_brick_field;
    import brick_field_pkg::*;

    localparam int PW = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         tick = 1'b0;
    logic         start = 1'b0;
    logic         btn_left = 1'b0;
    logic         btn_right = 1'b0;
    logic [3:0]   ball_row = 4'd9;
    logic [3:0]   ball_col = 4'd7;
    logic [1:0]   ball_dir = 2'b00;
    logic [191:0] data;
    logic         ball_step;
    logic         ball_rst_n;
    logic [7:0]   score;
    logic [1:0]   lives;
    logic [2:0]   state;

    brick_field dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .ball_row   (ball_row),
        .ball_col   (ball_col),
        .ball_dir   (ball_dir),
        .data       (data),
        .ball_step  (ball_step),
        .ball_rst_n (ball_rst_n),
        .score      (score),
        .lives      (lives),
        .state      (state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]   st;
        logic [7:0]   score;
        logic [1:0]   lives;
        logic [191:0] data;
    } exp_t;

    typedef struct {
        int         row;
        int         col;
        logic [1:0] dir;
        logic       bl;
        logic       br;
        int         clr_a;
        int         clr_b;
        int         d_pcol;
    } hit_vec_t;

    exp_t         sb_q[$];
    hit_vec_t     vecs[12];
    int           passed = 0;
    int           total = 0;
    int           step_count = 0;
    logic [191:0] exp_map;
    int           exp_pcol;
    int           exp_score;
    int           exp_lives;
    logic [2:0]   exp_state;

    function automatic logic [191:0] paddle_bits(input int col);
        logic [191:0] m;
        m = '0;
        for (int c = col; c < col + PW; c++) m[8'(176 + c)] = 1'b1;
        return m;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.st    = exp_state;
        e.score = 8'(exp_score);
        e.lives = 2'(exp_lives);
        e.data  = exp_map | paddle_bits(exp_pcol);
        return e;
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb_q.pop_front();
        check({tag, " state"}, 192'(state), 192'(e.st));
        check({tag, " score"}, 192'(score), 192'(e.score));
        check({tag, " lives"}, 192'(lives), 192'(e.lives));
        check({tag, " data"},  data,        e.data);
    endtask

    task automatic do_tick(input string tag, input int r, input int c, input logic [1:0] d,
                           input logic bl, input logic br, input logic exp_step);
        @(negedge clock);
        start     = 1'b0;
        ball_row  = 4'(r);
        ball_col  = 4'(c);
        ball_dir  = d;
        btn_left  = bl;
        btn_right = br;
        tick      = 1'b1;
        sb_q.push_back(snapshot());
        #1;
        check({tag, " ball_step"}, 192'(ball_step), 192'(exp_step));
        if (ball_step) step_count++;
        @(posedge clock);
        #1;
        tick      = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        sb_check(tag);
    endtask

    task automatic do_cycle(input string tag, input logic st);
        @(negedge clock);
        start = st;
        sb_q.push_back(snapshot());
        @(posedge clock);
        #1;
        sb_check(tag);
    endtask

    task automatic reload_expect();
        exp_map   = {128'd0, {64{1'b1}}};
        exp_pcol  = 6;
        exp_score = 0;
        exp_lives = 3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4,  7, UP_RIGHT,   1'b0, 1'b0, 55, -1,  0};
        vecs[1]  = '{4,  7, UP_RIGHT,   1'b0, 1'b0, 54, -1,  0};
        vecs[2]  = '{3,  9, UP_LEFT,    1'b0, 1'b0, 41, 58,  0};
        vecs[3]  = '{3,  7, DOWN_LEFT,  1'b0, 1'b0, 56, -1,  0};
        vecs[4]  = '{4,  0, UP_RIGHT,   1'b0, 1'b0, 48, -1,  0};
        vecs[5]  = '{0, 15, UP_LEFT,    1'b0, 1'b0, -1, -1,  0};
        vecs[6]  = '{10, 5, DOWN_LEFT,  1'b0, 1'b0, -1, -1,  0};
        vecs[7]  = '{4,  3, UP_LEFT,    1'b1, 1'b0, 51, -1,  1};
        vecs[8]  = '{4,  3, UP_LEFT,    1'b0, 1'b1, 52, -1, -1};
        vecs[9]  = '{9,  7, UP_RIGHT,   1'b1, 1'b1, -1, -1,  0};
        vecs[10] = '{3,  7, UP_RIGHT,   1'b0, 1'b0, 39, -1,  0};
        vecs[11] = '{3,  6, DOWN_RIGHT, 1'b0, 1'b0, 53, -1,  0};

        reload_expect();
        exp_state = 3'd0;

        repeat (2) @(negedge clock);
        sb_q.push_back(snapshot());
        #1;
        sb_check("reset");
        check("reset ball_step", 192'(ball_step), 192'(1'b0));
        check("reset ball_rst_n", 192'(ball_rst_n), 192'(1'b0));
        reset = 1'b1;

        exp_state = 3'd1;
        do_cycle("start", 1'b1);
        check("play ball_rst_n", 192'(ball_rst_n), 192'(1'b1));

        step_count = 0;
        for (int i = 0; i < 3; i++) do_tick("idle_tick", 9, 7, UP_RIGHT, 1'b0, 1'b0, 1'b1);
        check("step pulses", 192'(step_count), 192'(3));

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].clr_a >= 0) begin
                exp_map[8'(vecs[i].clr_a)] = 1'b0;
                exp_score++;
            end
            if (vecs[i].clr_b >= 0) begin
                exp_map[8'(vecs[i].clr_b)] = 1'b0;
                exp_score++;
            end
            exp_pcol += vecs[i].d_pcol;
            do_tick($sformatf("hit%0d", i), vecs[i].row, vecs[i].col, vecs[i].dir,
                    vecs[i].bl, vecs[i].br, 1'b1);
        end

        for (int i = 0; i < 10; i++) begin
            if (exp_pcol < 12) exp_pcol++;
            do_tick("btn_left", 9, 7, UP_RIGHT, 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 2; i++) do_tick("btn_both", 9, 7, UP_RIGHT, 1'b1, 1'b1, 1'b1);
        exp_pcol = 11;
        do_tick("btn_right", 9, 7, UP_RIGHT, 1'b0, 1'b1, 1'b1);

        for (int m = 0; m < 3; m++) begin
            exp_lives--;
            exp_pcol  = 6;
            exp_state = (exp_lives == 0) ? 3'd3 : 3'd2;
            do_tick("miss", 11, 5, UP_RIGHT, 1'b0, 1'b0, 1'b0);
            if (exp_lives != 0) begin
                check("serve ball_rst_n", 192'(ball_rst_n), 192'(1'b0));
                exp_state = 3'd1;
                do_cycle("serve_end", 1'b0);
                check("replay ball_rst_n", 192'(ball_rst_n), 192'(1'b1));
            end else begin
                check("over ball_rst_n", 192'(ball_rst_n), 192'(1'b1));
            end
        end

        do_tick("over_tick", 9, 7, UP_RIGHT, 1'b1, 1'b0, 1'b0);

        reload_expect();
        exp_state = 3'd0;
        do_cycle("over_restart", 1'b1);
        check("reload ball_rst_n", 192'(ball_rst_n), 192'(1'b0));
        exp_state = 3'd1;
        do_cycle("restart_play", 1'b1);

        for (int r = 3; r >= 0; r--) begin
            for (int c = 0; c < 16; c++) begin
                if (exp_map[8'(r * 16 + c)]) begin
                    exp_map[8'(r * 16 + c)] = 1'b0;
                    exp_score++;
                end
                if (exp_map == '0) exp_state = 3'd4;
                do_tick("clear_all", r + 1, c, UP_RIGHT, 1'b0, 1'b0, 1'b1);
            end
        end

        do_tick("win_tick", 5, 5, UP_RIGHT, 1'b0, 1'b0, 1'b0);

        reload_expect();
        exp_state = 3'd0;
        do_cycle("win_restart", 1'b1);
        do_cycle("idle_hold", 1'b0);

        exp_state = 3'd1;
        do_cycle("go_again", 1'b1);
        exp_map[55] = 1'b0;
        exp_score   = 1;
        do_tick("pre_reset", 4, 7, UP_RIGHT, 1'b0, 1'b0, 1'b1);

        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        reload_expect();
        exp_state = 3'd0;
        sb_q.push_back(snapshot());
        sb_check("async_reset");
        check("async ball_rst_n", 192'(ball_rst_n), 192'(1'b0));
        @(negedge clock);
        reset = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
